// File: rtl/time_keeper.sv
// Time-of-day keeper: a prescaler derives one-second ticks from clk and advances a
// 24-hour BCD clock (hh:mm) plus a binary seconds counter. The time is loadable with range checking.
module time_keeper #(
  parameter int unsigned TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run,
  input  logic       i_load,
  input  logic [3:0] i_dig0,
  input  logic [3:0] i_dig1,
  input  logic [3:0] i_dig2,
  input  logic [3:0] i_dig3,
  output logic [3:0] o_dig0,
  output logic [3:0] o_dig1,
  output logic [3:0] o_dig2,
  output logic [3:0] o_dig3,
  output logic [5:0] o_sec,
  output logic       o_min_pulse,
  output logic       o_load_err
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] prescaler;
  logic          load_valid;
  logic          sec_tick;
  logic [3:0]    nxt_dig0, nxt_dig1, nxt_dig2, nxt_dig3;

  always_comb begin
    load_valid = (i_dig3 <= 4'd2) && (i_dig2 <= 4'd9) &&
                 !((i_dig3 == 4'd2) && (i_dig2 > 4'd3)) &&
                 (i_dig1 <= 4'd5) && (i_dig0 <= 4'd9);
    sec_tick   = i_run && (prescaler == PRESC_MAX);
  end

  // Time one minute ahead of the current digits, with carries through to the hour.
  always_comb begin
    nxt_dig0 = o_dig0;
    nxt_dig1 = o_dig1;
    nxt_dig2 = o_dig2;
    nxt_dig3 = o_dig3;
    if (o_dig0 == 4'd9) begin
      nxt_dig0 = 4'd0;
      if (o_dig1 == 4'd5) begin
        nxt_dig1 = 4'd0;
        if ((o_dig3 == 4'd2) && (o_dig2 == 4'd3)) begin
          nxt_dig3 = 4'd0;
          nxt_dig2 = 4'd0;
        end else if (o_dig2 == 4'd9) begin
          nxt_dig2 = 4'd0;
          nxt_dig3 = o_dig3 + 4'd1;
        end else begin
          nxt_dig2 = o_dig2 + 4'd1;
        end
      end else begin
        nxt_dig1 = o_dig1 + 4'd1;
      end
    end else begin
      nxt_dig0 = o_dig0 + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler   <= '0;
      o_sec       <= 6'd0;
      o_dig0      <= 4'd0;
      o_dig1      <= 4'd0;
      o_dig2      <= 4'd0;
      o_dig3      <= 4'd0;
      o_min_pulse <= 1'b0;
      o_load_err  <= 1'b0;
    end else begin
      o_min_pulse <= 1'b0;
      o_load_err  <= 1'b0;
      // Any load, good or bad, blocks counting in that cycle.
      if (i_load) begin
        if (load_valid) begin
          o_dig0    <= i_dig0;
          o_dig1    <= i_dig1;
          o_dig2    <= i_dig2;
          o_dig3    <= i_dig3;
          o_sec     <= 6'd0;
          prescaler <= '0;
        end else begin
          o_load_err <= 1'b1;
        end
      end else if (i_run) begin
        if (sec_tick) begin
          prescaler <= '0;
          if (o_sec == 6'd59) begin
            o_sec       <= 6'd0;
            o_min_pulse <= 1'b1;
            o_dig0      <= nxt_dig0;
            o_dig1      <= nxt_dig1;
            o_dig2      <= nxt_dig2;
            o_dig3      <= nxt_dig3;
          end else begin
            o_sec <= o_sec + 6'd1;
          end
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with a four-cycle second; the expected values are worked out by hand.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_run = 1'b0;
  logic       i_load = 1'b0;
  logic [3:0] i_dig0 = 4'd0, i_dig1 = 4'd0, i_dig2 = 4'd0, i_dig3 = 4'd0;
  logic [3:0] o_dig0, o_dig1, o_dig2, o_dig3;
  logic [5:0] o_sec;
  logic       o_min_pulse, o_load_err;

  int vecs = 0;
  int errs = 0;

  time_keeper #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_load(i_load),
    .i_dig0(i_dig0), .i_dig1(i_dig1), .i_dig2(i_dig2), .i_dig3(i_dig3),
    .o_dig0(o_dig0), .o_dig1(o_dig1), .o_dig2(o_dig2), .o_dig3(o_dig3),
    .o_sec(o_sec), .o_min_pulse(o_min_pulse), .o_load_err(o_load_err)
  );

  always #5 clk = ~clk;

  wire [15:0] hhmm = {o_dig3, o_dig2, o_dig1, o_dig0};

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [15:0] v);
    {i_dig3, i_dig2, i_dig1, i_dig0} = v;
  endtask

  task automatic do_load(input logic [15:0] v);
    set_digits(v);
    i_load = 1'b1;
    step();
    i_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vecs++; if (hhmm !== 16'h0000) begin errs++; $display("FAIL reset_time got %h want 0000", hhmm); end
    vecs++; if (o_sec !== 6'd0) begin errs++; $display("FAIL reset_sec got %0d want 0", o_sec); end
    vecs++; if ({o_min_pulse, o_load_err} !== 2'b00) begin
      errs++; $display("FAIL reset_pulses got %b want 00", {o_min_pulse, o_load_err});
    end
  endtask

  task automatic test_count_minute();
    int pulses = 0;
    i_run = 1'b1;
    for (int k = 1; k <= 240; k++) begin
      step();
      if (o_min_pulse === 1'b1) pulses++;
      vecs++;
      if (o_sec !== 6'((k / 4) % 60)) begin
        errs++; $display("FAIL count_sec k=%0d got %0d want %0d", k, o_sec, (k / 4) % 60);
      end
    end
    i_run = 1'b0;
    vecs++; if (hhmm !== 16'h0001) begin errs++; $display("FAIL count_time got %h want 0001", hhmm); end
    vecs++; if (o_min_pulse !== 1'b1) begin errs++; $display("FAIL count_pulse_last got %b want 1", o_min_pulse); end
    vecs++; if (pulses != 1) begin errs++; $display("FAIL count_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_midnight_rollover();
    do_load(16'h2359);
    vecs++; if (hhmm !== 16'h2359 || o_sec !== 6'd0 || o_min_pulse !== 1'b0) begin
      errs++; $display("FAIL load_2359 got %h s%0d p%b want 2359 s0 p0", hhmm, o_sec, o_min_pulse);
    end
    i_run = 1'b1;
    repeat (236) step();
    vecs++; if (o_sec !== 6'd59 || hhmm !== 16'h2359) begin
      errs++; $display("FAIL pre_wrap got %h s%0d want 2359 s59", hhmm, o_sec);
    end
    repeat (3) step();
    vecs++; if (o_sec !== 6'd59 || o_min_pulse !== 1'b0) begin
      errs++; $display("FAIL pre_tick got s%0d p%b want s59 p0", o_sec, o_min_pulse);
    end
    step();
    vecs++; if (hhmm !== 16'h0000 || o_sec !== 6'd0 || o_min_pulse !== 1'b1) begin
      errs++; $display("FAIL midnight got %h s%0d p%b want 0000 s0 p1", hhmm, o_sec, o_min_pulse);
    end
    step();
    vecs++; if (o_min_pulse !== 1'b0) begin errs++; $display("FAIL midnight_pulse_len got %b want 0", o_min_pulse); end
    i_run = 1'b0;
  endtask

  task automatic test_hour_carry();
    logic [15:0] start [2] = '{16'h0959, 16'h1959};
    logic [15:0] want  [2] = '{16'h1000, 16'h2000};
    for (int i = 0; i < 2; i++) begin
      do_load(start[i]);
      i_run = 1'b1;
      repeat (240) step();
      i_run = 1'b0;
      vecs++; if (hhmm !== want[i] || o_sec !== 6'd0) begin
        errs++; $display("FAIL hour_carry got %h s%0d want %h s0", hhmm, o_sec, want[i]);
      end
    end
  endtask

  task automatic test_bad_load();
    do_load(16'h0745);
    vecs++; if (hhmm !== 16'h0745 || o_load_err !== 1'b0) begin
      errs++; $display("FAIL good_load got %h e%b want 0745 e0", hhmm, o_load_err);
    end
    i_run = 1'b1;
    repeat (3) step();
    // Prescaler is now at its last count, so an ignored load would otherwise tick here.
    set_digits(16'h2400);
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    vecs++; if (hhmm !== 16'h0745 || o_sec !== 6'd0 || o_load_err !== 1'b1) begin
      errs++; $display("FAIL bad_2400 got %h s%0d e%b want 0745 s0 e1", hhmm, o_sec, o_load_err);
    end
    step();
    vecs++; if (o_sec !== 6'd1 || o_load_err !== 1'b0) begin
      errs++; $display("FAIL after_2400 got s%0d e%b want s1 e0", o_sec, o_load_err);
    end
    set_digits(16'h0560);
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    vecs++; if (hhmm !== 16'h0745 || o_sec !== 6'd1 || o_load_err !== 1'b1) begin
      errs++; $display("FAIL bad_min_tens got %h s%0d e%b want 0745 s1 e1", hhmm, o_sec, o_load_err);
    end
    repeat (3) step();
    vecs++; if (o_sec !== 6'd1 || o_load_err !== 1'b0) begin
      errs++; $display("FAIL bad_no_count got s%0d e%b want s1 e0", o_sec, o_load_err);
    end
    step();
    vecs++; if (o_sec !== 6'd2) begin errs++; $display("FAIL bad_resume got s%0d want s2", o_sec); end
    i_run = 1'b0;
  endtask

  task automatic test_load_on_tick();
    do_load(16'h0815);
    i_run = 1'b1;
    repeat (239) step();
    vecs++; if (o_sec !== 6'd59 || hhmm !== 16'h0815) begin
      errs++; $display("FAIL lt_setup got %h s%0d want 0815 s59", hhmm, o_sec);
    end
    do_load(16'h1230);
    vecs++; if (hhmm !== 16'h1230 || o_sec !== 6'd0 || o_min_pulse !== 1'b0) begin
      errs++; $display("FAIL load_tick got %h s%0d p%b want 1230 s0 p0", hhmm, o_sec, o_min_pulse);
    end
    repeat (3) step();
    vecs++; if (o_sec !== 6'd0 || o_min_pulse !== 1'b0 || hhmm !== 16'h1230) begin
      errs++; $display("FAIL lt_presc got %h s%0d p%b want 1230 s0 p0", hhmm, o_sec, o_min_pulse);
    end
    step();
    vecs++; if (o_sec !== 6'd1) begin errs++; $display("FAIL lt_first_tick got s%0d want s1", o_sec); end
  endtask

  task automatic test_pause();
    // Running from s1 with prescaler 0: two more edges leave it at 2.
    repeat (2) step();
    i_run = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (k % 25 == 24) begin
        vecs++; if (o_sec !== 6'd1) begin errs++; $display("FAIL pause_hold k=%0d got s%0d want s1", k, o_sec); end
      end
    end
    i_run = 1'b1;
    step();
    vecs++; if (o_sec !== 6'd1) begin errs++; $display("FAIL pause_remaining got s%0d want s1", o_sec); end
    step();
    vecs++; if (o_sec !== 6'd2) begin errs++; $display("FAIL pause_tick got s%0d want s2", o_sec); end
    i_run = 1'b0;
  endtask

  task automatic test_reset_running();
    do_load(16'h1547);
    i_run = 1'b1;
    repeat (132) step();
    vecs++; if (hhmm !== 16'h1547 || o_sec !== 6'd33) begin
      errs++; $display("FAIL run_154733 got %h s%0d want 1547 s33", hhmm, o_sec);
    end
    reset = 1'b1;
    set_digits(16'h1230);
    i_load = 1'b1;
    step();
    vecs++; if (hhmm !== 16'h0000 || o_sec !== 6'd0 || {o_min_pulse, o_load_err} !== 2'b00) begin
      errs++; $display("FAIL reset_load got %h s%0d pe%b want 0000 s0 00", hhmm, o_sec,
                       {o_min_pulse, o_load_err});
    end
    set_digits(16'h2400);
    step();
    vecs++; if (o_load_err !== 1'b0 || hhmm !== 16'h0000) begin
      errs++; $display("FAIL reset_badload got %h e%b want 0000 e0", hhmm, o_load_err);
    end
    reset = 1'b0;
    i_load = 1'b0;
    repeat (3) step();
    vecs++; if (o_sec !== 6'd0) begin errs++; $display("FAIL post_reset_hold got s%0d want s0", o_sec); end
    step();
    vecs++; if (o_sec !== 6'd1) begin errs++; $display("FAIL post_reset_tick got s%0d want s1", o_sec); end
    i_run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_minute();
    test_midnight_rollover();
    test_hour_carry();
    test_bad_load();
    test_load_on_tick();
    test_pause();
    test_reset_running();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 50000000, meaning clk cycles per second (>=2).
REQ-002 The block SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port i_run  input  1  count enable; high means time advances.
REQ-005 The block SHALL have port i_load  input  1  one-cycle load strobe from the digit-load mux.
REQ-006 The block SHALL have ports i_dig0, i_dig1, i_dig2, i_dig3  input  4 each  BCD load value: minute units, minute tens, hour units, hour tens.
REQ-007 The block SHALL have ports o_dig0, o_dig1, o_dig2, o_dig3  output  4 each  current time in BCD, same digit order as i_dig*.
REQ-008 The block SHALL have port o_sec  output  6  current seconds, binary 0..59.
REQ-009 The block SHALL have port o_min_pulse  output  1  one-cycle pulse on each minute rollover.
REQ-010 The block SHALL have port o_load_err  output  1  one-cycle pulse when a load is rejected.
REQ-011 All outputs SHALL be driven directly from registers.

Function
REQ-012 The block SHALL contain a prescaler that counts 0..TICKS_PER_SEC-1 while i_run=1 and holds its value while i_run=0.
REQ-013 A second tick SHALL occur in a cycle where i_run=1 and the prescaler equals TICKS_PER_SEC-1; on that tick the prescaler SHALL return to 0 and o_sec SHALL increment.
REQ-014 When o_sec=59 and a second tick occurs, o_sec SHALL become 0 and the minute SHALL advance in the same edge.
REQ-015 A minute advance SHALL proceed as follows: dig0 9->0 carries into dig1; dig1 5->0 carries into the hour; the hour follows 09->10, 19->20, 23->00.
REQ-016 o_min_pulse SHALL be 1 for exactly the cycle after the edge on which o_sec wrapped 59->0; it SHALL NOT pulse on a load.
REQ-017 A load SHALL be valid iff all of the following hold: i_dig3<=2; i_dig2<=9; i_dig3=2 implies i_dig2<=3; i_dig1<=5; i_dig0<=9.
REQ-018 A valid load SHALL update o_dig0..3 to i_dig0..3 on the next clk edge (latency 1), and on the same edge SHALL clear o_sec and the prescaler to 0.
REQ-019 An invalid load SHALL leave all time state unchanged, including counting that cycle, and SHALL pulse o_load_err high for one cycle (latency 1).
REQ-020 When i_load and a second tick coincide, the load SHALL take priority: a valid load suppresses the tick and its carry, and no o_min_pulse is issued.
REQ-021 A load SHALL be accepted regardless of i_run.
REQ-022 i_load held high for N cycles SHALL be treated as N independent loads.
REQ-023 The digit registers SHALL never hold a value outside the valid ranges in REQ-017.

Reset
REQ-024 When reset=1 at a clk edge, the block SHALL set o_dig0..3 to 0, o_sec to 0, the prescaler to 0, o_min_pulse to 0, and o_load_err to 0.
REQ-025 Reset SHALL override i_load, i_run and any pending tick in the same cycle.
REQ-026 After reset deasserts, counting SHALL resume from 00:00:00, with the first second tick occurring TICKS_PER_SEC cycles after the first i_run=1 cycle.

Verification (TICKS_PER_SEC=4)
REQ-027 The bench SHALL apply reset, then i_run=1 for 240 cycles and check: o_sec steps every 4 cycles; after 240 cycles time=00:01, o_sec=0; exactly one o_min_pulse.
REQ-028 The bench SHALL load 2,3,5,9 (23:59), set o_sec to 59 via 236 run cycles, then tick and check: time=00:00, o_sec=0, o_min_pulse=1 for one cycle.
REQ-029 The bench SHALL apply an invalid load of 2,4,0,0 (24:00) and separately of hour-tens 0 with minute-tens 6, and check: o_load_err=1 for one cycle and the time unchanged.
REQ-030 The bench SHALL apply a load of 1,2,3,0 (12:30) in the same cycle as a second tick at o_sec=59 and check: time=12:30, o_sec=0, prescaler 0, no o_min_pulse.
REQ-031 The bench SHALL apply i_run=0 for 100 cycles mid-second and check that o_sec and the prescaler hold, then that the tick occurs at the remaining count after i_run=1.
REQ-032 The bench SHALL assert reset while running at 15:47:33 and check that all outputs are 0 on the next edge, even with i_load=1 that cycle.
